// File: rtl/scmp_bus_demux_if.sv
// Demultiplexed SC/MP bus bundle: core-side multiplexed strobes plus the flat memory port.
// The slave modport is the demux view; the master modport is the core/memory side.
interface scmp_bus_demux_if;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_d_o;
    logic        cpu_ads_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_d_i;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_addr, cpu_d_o, cpu_ads_n, cpu_rd_n, cpu_wr_n, mem_rdata,
        output cpu_d_i, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output cpu_addr, cpu_d_o, cpu_ads_n, cpu_rd_n, cpu_wr_n, mem_rdata,
        input  cpu_d_i, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/scmp_bus_demux.sv
// SC/MP bus demultiplexer: latches address nibble and cycle flags at ADS, issues single-cycle
// memory requests, holds read data and tracks halt. Optional SCMP_BUS_CYCCNT_EN adds cyc_cnt.
module scmp_bus_demux #(
    parameter int unsigned RD_LAT         = 1,
    parameter bit          HALT_AUTO_CONT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    scmp_bus_demux_if.slave    bus,
    output logic               flag_h,
    output logic               flag_d,
    output logic               flag_i,
    output logic               flag_r,
    output logic               halt_o,
    input  logic               cont_i,
    output logic               bus_err
`ifdef SCMP_BUS_CYCCNT_EN
    ,
    output logic [15:0]        cyc_cnt
`endif
);

    localparam logic [1:0] RdLatCnt = RD_LAT[1:0];

    typedef enum logic [2:0] {StIdle, StAddr, StRdWait, StRdHold, StWrite} state_e;

    state_e      state_q, state_d;
    logic [3:0]  addr_hi_q, addr_hi_d;
    logic [3:0]  flags_q, flags_d;  // {h, d, i, r}
    logic [7:0]  d_i_q, d_i_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic        rd_n_q, wr_n_q;
    logic        set_halt;

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        flags_d   = flags_q;
        d_i_d     = d_i_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        err_d     = err_q;
        set_halt  = 1'b0;

        if (!bus.cpu_rd_n && !bus.cpu_wr_n) err_d = 1'b1;
        if (state_q == StIdle &&
            ((!bus.cpu_rd_n && rd_n_q) || (!bus.cpu_wr_n && wr_n_q))) err_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (!bus.cpu_ads_n) begin
                    addr_hi_d = bus.cpu_d_o[3:0];
                    flags_d   = bus.cpu_d_o[7:4];
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (!bus.cpu_rd_n && !bus.cpu_wr_n) begin
                    state_d = StAddr;
                end else if (!bus.cpu_rd_n) begin
                    mem_rd_d = 1'b1;
                    cnt_d    = RdLatCnt;
                    state_d  = StRdWait;
                end else if (!bus.cpu_wr_n) begin
                    mem_wr_d = 1'b1;
                    wdata_d  = bus.cpu_d_o;
                    state_d  = StWrite;
                end else if (!bus.cpu_ads_n) begin
                    addr_hi_d = bus.cpu_d_o[3:0];
                    flags_d   = bus.cpu_d_o[7:4];
                end
            end
            StRdWait: begin
                // Strobe released before data arrived: abort without touching cpu_d_i.
                if (bus.cpu_rd_n) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == 2'd0) begin
                    d_i_d   = bus.mem_rdata;
                    state_d = StRdHold;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StRdHold: begin
                if (bus.cpu_rd_n) begin
                    state_d  = StIdle;
                    set_halt = flags_q[3] & flags_q[1];
                end
            end
            StWrite: begin
                if (bus.cpu_wr_n) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (HALT_AUTO_CONT)  halt_d = 1'b0;
        else if (cont_i)     halt_d = 1'b0;
        else                 halt_d = halt_q;
        if (set_halt)        halt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_hi_q <= '0;
            flags_q   <= '0;
            d_i_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            flags_q   <= flags_d;
            d_i_q     <= d_i_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            rd_n_q    <= bus.cpu_rd_n;
            wr_n_q    <= bus.cpu_wr_n;
        end
    end

`ifdef SCMP_BUS_CYCCNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic        cyc_done;

    assign cyc_done = (state_q == StRdHold && bus.cpu_rd_n) ||
                      (state_q == StWrite && bus.cpu_wr_n);

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (cyc_done) cyc_cnt_d = cyc_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt_q <= '0;
        else        cyc_cnt_q <= cyc_cnt_d;
    end

    assign cyc_cnt = cyc_cnt_q;
`endif

    assign bus.mem_addr  = {addr_hi_q, bus.cpu_addr};
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_d_i   = d_i_q;
    assign flag_h        = flags_q[3];
    assign flag_d        = flags_q[2];
    assign flag_i        = flags_q[1];
    assign flag_r        = flags_q[0];
    assign halt_o        = halt_q;
    assign bus_err       = err_q;

    a_rd_lat_legal: assert property (@(posedge clk) RD_LAT <= 3)
        else $error("RD_LAT must be in 0..3");

endmodule
